// File: rtl/xgmm_mem_responder.sv
// xgmm_mem_responder: memory-side responder for the XG memory manager burst
// interface. Each accepted request moves one aligned four-word burst between
// the initiator and a single-port synchronous RAM with RD_LAT read latency.
module xgmm_mem_responder #(
   parameter int RD_LAT = 1
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        mem_req,
   input  logic        mem_wren,
   input  logic [16:0] mem_addr,
   input  logic [15:0] to_mem,
   output logic        mem_ready,
   output logic [1:0]  mem_offset,
   output logic [15:0] from_mem,
   output logic [16:0] ram_addr,
   output logic        ram_wren,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_GAP} state_t;

   state_t                 state;
   logic [14:0]            base;      // aligned burst base, address bits [16:2]
   logic [1:0]             cnt;       // next word to present to the RAM
   logic                   issuing;   // read addresses still being presented
   logic                   wr_ready;  // write word strobe
   logic [1:0]             wr_off;    // write word index
   // Read return delay line: stage 0 is aligned with the address on ram_addr,
   // stage RD_LAT with the matching word on ram_rdata.
   logic [RD_LAT:0]        vld_pipe;
   logic [RD_LAT:0][1:0]   off_pipe;

   // Burst word index bits of the request are deliberately discarded.
   logic [1:0]             unused_lsb;
   assign unused_lsb = mem_addr[1:0];

   // Burst sequencer and read-return delay line.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         base     <= '0;
         cnt      <= '0;
         issuing  <= 1'b0;
         wr_ready <= 1'b0;
         wr_off   <= '0;
         ram_addr <= '0;
         ram_wren <= 1'b0;
         busy     <= 1'b0;
         vld_pipe <= '0;
         off_pipe <= '0;
      end else begin
         for (int i = 1; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            off_pipe[i] <= off_pipe[i-1];
         end
         vld_pipe[0] <= 1'b0;

         case (state)
            S_IDLE: begin
               if (mem_req) begin
                  // Word 0 goes out on the accept edge, so the counter
                  // continues from word 1.
                  base     <= mem_addr[16:2];
                  ram_addr <= {mem_addr[16:2], 2'b00};
                  cnt      <= 2'd1;
                  busy     <= 1'b1;
                  if (mem_wren) begin
                     state    <= S_WRITE;
                     ram_wren <= 1'b1;
                     wr_ready <= 1'b1;
                     wr_off   <= 2'd0;
                  end else begin
                     state       <= S_READ;
                     issuing     <= 1'b1;
                     vld_pipe[0] <= 1'b1;
                     off_pipe[0] <= 2'd0;
                  end
               end
            end

            S_READ: begin
               if (issuing) begin
                  ram_addr    <= {base, cnt};
                  vld_pipe[0] <= 1'b1;
                  off_pipe[0] <= cnt;
                  cnt         <= cnt + 2'd1;
                  if (cnt == 2'd3)
                     issuing <= 1'b0;
               end
               // Leave once the last word is on the return side.
               if (vld_pipe[RD_LAT] && off_pipe[RD_LAT] == 2'd3)
                  state <= S_GAP;
            end

            S_WRITE: begin
               if (wr_off == 2'd3) begin
                  state    <= S_GAP;
                  wr_ready <= 1'b0;
                  ram_wren <= 1'b0;
                  wr_off   <= 2'd0;
               end else begin
                  ram_addr <= {base, cnt};
                  wr_off   <= cnt;
                  cnt      <= cnt + 2'd1;
               end
            end

            S_GAP: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_ready  = wr_ready | vld_pipe[RD_LAT];
   assign mem_offset = vld_pipe[RD_LAT] ? off_pipe[RD_LAT] : wr_off;
   assign from_mem   = ram_rdata;
   assign ram_wdata  = to_mem;

endmodule

// File: tb/tb_xgmm_mem_responder.sv
// Bench for xgmm_mem_responder: two instances (RD_LAT=1 and RD_LAT=3), each
// with its own RAM, checked every cycle against a timing-table model.
module tb_xgmm_mem_responder;

   localparam int RING = 4096;

   typedef struct packed {
      logic        rdy;
      logic        busy;
      logic        wren;
      logic        achk;
      logic        ochk;
      logic        dchk;
      logic [16:0] addr;
      logic [1:0]  off;
      logic [15:0] data;
   } exp_t;

   logic clk_sys = 1'b0;
   initial forever #5 clk_sys = ~clk_sys;

   logic        rst_n     [2];
   logic        mem_req   [2];
   logic        mem_wren  [2];
   logic [16:0] mem_addr  [2];
   logic [15:0] to_mem    [2];
   logic        mem_ready [2];
   logic [1:0]  mem_offset[2];
   logic [15:0] from_mem  [2];
   logic [16:0] ram_addr  [2];
   logic        ram_wren  [2];
   logic [15:0] ram_wdata [2];
   logic [15:0] ram_rdata [2];
   logic        busy      [2];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   free_at [2];
   bit   cmp_en  [2];
   exp_t expq    [2][RING];
   bit [15:0] ram    [2][131072];
   bit [15:0] shadow [2][131072];
   bit [16:0] ap     [2][4];

   xgmm_mem_responder #(.RD_LAT(1)) u_dut0 (
      .clk_sys(clk_sys), .rst_n(rst_n[0]), .mem_req(mem_req[0]), .mem_wren(mem_wren[0]),
      .mem_addr(mem_addr[0]), .to_mem(to_mem[0]), .mem_ready(mem_ready[0]),
      .mem_offset(mem_offset[0]), .from_mem(from_mem[0]), .ram_addr(ram_addr[0]),
      .ram_wren(ram_wren[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]), .busy(busy[0]));

   xgmm_mem_responder #(.RD_LAT(3)) u_dut1 (
      .clk_sys(clk_sys), .rst_n(rst_n[1]), .mem_req(mem_req[1]), .mem_wren(mem_wren[1]),
      .mem_addr(mem_addr[1]), .to_mem(to_mem[1]), .mem_ready(mem_ready[1]),
      .mem_offset(mem_offset[1]), .from_mem(from_mem[1]), .ram_addr(ram_addr[1]),
      .ram_wren(ram_wren[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]), .busy(busy[1]));

   // RAM read data is the word addressed RD_LAT cycles earlier.
   assign ram_rdata[0] = ram[0][ap[0][1]];
   assign ram_rdata[1] = ram[1][ap[1][3]];

   function automatic int lat(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
      end
   endtask

   // Reference model: on each accept, lay the whole burst out in a per-cycle
   // expectation table using the documented cycle offsets.
   task automatic model_step(int i);
      int          c;
      int          l;
      exp_t        e;
      logic [16:0] b;
      c = cyc;
      l = lat(i);
      e = expq[i][c % RING];
      expq[i][c % RING] = '0;
      if (e.wren) shadow[i][e.addr] = to_mem[i];
      if (rst_n[i] !== 1'b1) begin
         for (int k = 1; k <= 12; k++) expq[i][(c + k) % RING] = '0;
         expq[i][(c + 1) % RING].achk = 1'b1;
         expq[i][(c + 1) % RING].ochk = 1'b1;
         free_at[i] = c + 1;
         cmp_en[i]  = 1'b1;
      end else if (cmp_en[i] && c >= free_at[i] && mem_req[i] === 1'b1) begin
         b = {mem_addr[i][16:2], 2'b00};
         if (mem_wren[i]) begin
            for (int k = 0; k < 4; k++) begin
               expq[i][(c + 1 + k) % RING].rdy  = 1'b1;
               expq[i][(c + 1 + k) % RING].wren = 1'b1;
               expq[i][(c + 1 + k) % RING].achk = 1'b1;
               expq[i][(c + 1 + k) % RING].addr = b + 17'(k);
               expq[i][(c + 1 + k) % RING].ochk = 1'b1;
               expq[i][(c + 1 + k) % RING].off  = 2'(k);
            end
            for (int k = 1; k <= 5; k++) expq[i][(c + k) % RING].busy = 1'b1;
            free_at[i] = c + 6;
         end else begin
            for (int k = 0; k < 4; k++) begin
               expq[i][(c + 1 + k) % RING].achk = 1'b1;
               expq[i][(c + 1 + k) % RING].addr = b + 17'(k);
               expq[i][(c + 1 + l + k) % RING].rdy  = 1'b1;
               expq[i][(c + 1 + l + k) % RING].ochk = 1'b1;
               expq[i][(c + 1 + l + k) % RING].off  = 2'(k);
               expq[i][(c + 1 + l + k) % RING].dchk = 1'b1;
               expq[i][(c + 1 + l + k) % RING].data = shadow[i][b + 17'(k)];
            end
            for (int k = 1; k <= 5 + l; k++) expq[i][(c + k) % RING].busy = 1'b1;
            free_at[i] = c + 6 + l;
         end
      end
   endtask

   // Environment RAMs, model update and cycle counter, all on the rising edge.
   initial forever begin
      @(posedge clk_sys);
      for (int i = 0; i < 2; i++) begin
         if (ram_wren[i] === 1'b1) ram[i][ram_addr[i]] = ram_wdata[i];
         ap[i][3] = ap[i][2];
         ap[i][2] = ap[i][1];
         ap[i][1] = ram_addr[i];
         model_step(i);
      end
      cyc++;
   end

   task automatic compare(int i);
      exp_t e;
      e = expq[i][cyc % RING];
      chk("mem_ready", i, 32'(mem_ready[i]), 32'(e.rdy));
      chk("busy",      i, 32'(busy[i]),      32'(e.busy));
      chk("ram_wren",  i, 32'(ram_wren[i]),  32'(e.wren));
      if (e.achk) chk("ram_addr",   i, 32'(ram_addr[i]),   32'(e.addr));
      if (e.ochk) chk("mem_offset", i, 32'(mem_offset[i]), 32'(e.off));
      if (e.dchk) chk("from_mem",   i, 32'(from_mem[i]),   32'(e.data));
      if (e.wren) chk("ram_wdata",  i, 32'(ram_wdata[i]),  32'(to_mem[i]));
   endtask

   // Single compare process, just after each rising edge.
   initial forever begin
      @(posedge clk_sys);
      #1;
      for (int i = 0; i < 2; i++) if (cmp_en[i]) compare(i);
   end

   task automatic wait_idle(int i);
      int n;
      n = 0;
      while (busy[i] !== 1'b0 && n < 40) begin
         @(negedge clk_sys);
         to_mem[i] = 16'($urandom);
         n++;
      end
      if (busy[i] !== 1'b0) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle_timeout dut%0d cyc %0d: busy stuck at %b", i, cyc, busy[i]);
      end
   endtask

   task automatic read_measure(int i, logic [16:0] a, output int acc, output int first,
                               output int nrdy, output int last, output int idle_at);
      mem_req[i] = 1'b1; mem_wren[i] = 1'b0; mem_addr[i] = a;
      acc = cyc; first = -1; nrdy = 0; last = -1; idle_at = -1;
      for (int k = 1; k <= 30 && idle_at < 0; k++) begin
         @(negedge clk_sys);
         mem_req[i] = 1'b0;
         to_mem[i]  = 16'($urandom);
         if (mem_ready[i] === 1'b1) begin
            if (first < 0) first = k;
            nrdy++;
            last = k;
         end
         if (busy[i] === 1'b0) idle_at = k;
      end
   endtask

   task automatic rand_bursts(int i, int n);
      logic [16:0] regions [4];
      int h;
      int rc;
      regions[0] = 17'h00040; regions[1] = 17'h00100;
      regions[2] = 17'h10004; regions[3] = 17'h1FFFC;
      for (int b = 0; b < n; b++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk_sys);
            to_mem[i] = 16'($urandom); mem_addr[i] = 17'($urandom); mem_wren[i] = 1'($urandom);
         end
         h  = $urandom_range(0, 7);
         rc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
         mem_req[i]  = 1'b1;
         mem_wren[i] = 1'($urandom);
         mem_addr[i] = regions[$urandom_range(0, 3)] | 17'($urandom_range(0, 3));
         for (int k = 1; k <= 12; k++) begin
            @(negedge clk_sys);
            to_mem[i]   = 16'($urandom);
            mem_addr[i] = 17'($urandom);
            mem_wren[i] = 1'($urandom);
            if (k > h) mem_req[i] = 1'b0;
            rst_n[i] = (rc == k) ? 1'b0 : 1'b1;
         end
         rst_n[i] = 1'b1;
         wait_idle(i);
      end
   endtask

   int a1, f1, n1, l1, i1, a2, f2, n2, l2, i2, wcnt, bcnt;

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; mem_req[i] = 1'b0; mem_wren[i] = 1'b0;
         mem_addr[i] = '0; to_mem[i] = '0; free_at[i] = 0; cmp_en[i] = 1'b0;
      end
      repeat (3) @(negedge clk_sys);
      for (int i = 0; i < 2; i++) begin
         chk("reset_ready", i, 32'(mem_ready[i]), 32'd0);
         chk("reset_busy",  i, 32'(busy[i]),      32'd0);
         chk("reset_addr",  i, 32'(ram_addr[i]),  32'd0);
         rst_n[i] = 1'b1;
      end
      repeat (2) @(negedge clk_sys);

      // Write 0xA000..0xA003 to 0x40, then read it back with a one-cycle pulse.
      mem_req[0] = 1'b1; mem_wren[0] = 1'b1; mem_addr[0] = 17'h00040;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_sys);
         mem_req[0] = 1'b0;
         to_mem[0]  = 16'hA000 + 16'(k - 1);
         chk("wr_lit_offset", 0, 32'(mem_offset[0]), 32'(k - 1));
      end
      wait_idle(0);
      for (int j = 0; j < 4; j++)
         chk("ram_content", 0, 32'(ram[0][17'h40 + 17'(j)]), 32'(16'hA000 + 16'(j)));
      mem_req[0] = 1'b1; mem_wren[0] = 1'b0; mem_addr[0] = 17'h00040;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_sys);
         mem_req[0] = 1'b0;
         chk("rd_lit_ready", 0, 32'(mem_ready[0]), 32'(k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) begin
            chk("rd_lit_offset", 0, 32'(mem_offset[0]), 32'(k - 2));
            chk("rd_lit_data",   0, 32'(from_mem[0]),   32'(16'hA000 + 16'(k - 2)));
         end
      end
      wait_idle(0);

      // Unaligned read address stays inside its four-word block.
      mem_req[0] = 1'b1; mem_wren[0] = 1'b0; mem_addr[0] = 17'h10007;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_sys);
         mem_req[0] = 1'b0;
         chk("unaligned_addr", 0, 32'(ram_addr[0]), 32'(17'h10004 + 17'(k - 1)));
      end
      wait_idle(0);

      // Request held past the first word must not start a second burst.
      mem_req[0] = 1'b1; mem_wren[0] = 1'b1; mem_addr[0] = 17'h00080;
      wcnt = 0; bcnt = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk_sys);
         to_mem[0] = 16'($urandom);
         if (ram_wren[0] === 1'b1) wcnt++;
         if (k == 5) chk("held_gap_ready", 0, 32'(mem_ready[0]), 32'd0);
         if (k >= 6 && busy[0] !== 1'b0) bcnt++;
         if (k >= 2) mem_req[0] = 1'b0;
      end
      chk("held_wren_count", 0, 32'(wcnt), 32'd4);
      chk("held_no_rerun",   0, 32'(bcnt), 32'd0);

      // Reset on the edge ending word 0 leaves only word 0 written.
      mem_req[0] = 1'b1; mem_wren[0] = 1'b1; mem_addr[0] = 17'h00200;
      @(negedge clk_sys);
      mem_req[0] = 1'b0; to_mem[0] = 16'hB000; rst_n[0] = 1'b0;
      @(negedge clk_sys);
      chk("rst_mid_ready", 0, 32'(mem_ready[0]), 32'd0);
      chk("rst_mid_busy",  0, 32'(busy[0]),      32'd0);
      chk("rst_mid_wren",  0, 32'(ram_wren[0]),  32'd0);
      rst_n[0] = 1'b1; to_mem[0] = 16'hB001;
      repeat (6) @(negedge clk_sys);
      chk("rst_mid_word0", 0, 32'(ram[0][17'h200]), 32'h0000B000);
      chk("rst_mid_word1", 0, 32'(ram[0][17'h201]), 32'd0);

      // RD_LAT=3: two reads back to back, second issued as busy falls.
      read_measure(1, 17'h00300, a1, f1, n1, l1, i1);
      read_measure(1, 17'h00304, a2, f2, n2, l2, i2);
      chk("lat3_first_a",  1, 32'(f1), 32'd4);
      chk("lat3_count_a",  1, 32'(n1), 32'd4);
      chk("lat3_last_a",   1, 32'(l1), 32'd7);
      chk("lat3_first_b",  1, 32'(f2), 32'd4);
      chk("lat3_count_b",  1, 32'(n2), 32'd4);
      chk("lat3_last_b",   1, 32'(l2), 32'd7);
      chk("lat3_spacing",  1, 32'(a2 - a1), 32'd9);
      wait_idle(1);

      rand_bursts(0, 40);
      rand_bursts(1, 40);
      repeat (12) @(negedge clk_sys);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
